// File: rtl/rob_pkg.sv
// Shared types and widths for the reorder buffer: entry layout, tag and pointer widths.
// Register-file sizes mirror the core's physical data/status register counts.
package rob_pkg;

  localparam int ROB_DEPTH     = 16;
  localparam int ROB_NUM_D_REG = 32;
  localparam int ROB_NUM_S_REG = 16;

  localparam int ROB_TAG_W = $clog2(ROB_DEPTH);
  localparam int ROB_PTR_W = ROB_TAG_W + 1;
  localparam int D_ADDR_W  = $clog2(ROB_NUM_D_REG);
  localparam int S_ADDR_W  = $clog2(ROB_NUM_S_REG);

  typedef logic [ROB_TAG_W-1:0] rob_tag_t;
  typedef logic [ROB_PTR_W-1:0] rob_ptr_t;

  typedef struct packed {
    logic                busy;
    logic                done;
    logic                write_rw;
    logic [D_ADDR_W-1:0] prev_rw_addr;
    logic                write_rs;
    logic [S_ADDR_W-1:0] prev_rs_addr;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: rename allocates at tail, pipes a/c mark entries done by tag,
// the oldest done entry retires through registered commit outputs, one per cycle.
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int DEPTH     = ROB_DEPTH,
  parameter int NUM_D_REG = ROB_NUM_D_REG,
  parameter int NUM_S_REG = ROB_NUM_S_REG
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         alloc_valid,
  output logic                         alloc_ready,
  input  logic                         alloc_write_rw,
  input  logic [$clog2(NUM_D_REG)-1:0] alloc_prev_rw_addr,
  input  logic                         alloc_write_rs,
  input  logic [$clog2(NUM_S_REG)-1:0] alloc_prev_rs_addr,
  output logic [$clog2(DEPTH)-1:0]     alloc_tag,
  input  logic                         cmp_a_valid,
  input  logic [$clog2(DEPTH)-1:0]     cmp_a_tag,
  input  logic                         cmp_c_valid,
  input  logic [$clog2(DEPTH)-1:0]     cmp_c_tag,
  input  logic                         flush,
  output logic                         commit_valid,
  output logic                         commit_write_rw,
  output logic [$clog2(NUM_D_REG)-1:0] commit_prev_rw_addr,
  output logic                         commit_write_rs,
  output logic [$clog2(NUM_S_REG)-1:0] commit_prev_rs_addr,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int TAG_W = $clog2(DEPTH);
  localparam int PTR_W = TAG_W + 1;

  rob_entry_t             entries [DEPTH];
  logic       [PTR_W-1:0] head;
  logic       [PTR_W-1:0] tail;
  logic       [TAG_W-1:0] head_idx;
  logic       [TAG_W-1:0] tail_idx;
  rob_entry_t             head_entry;
  logic                   full;
  logic                   do_alloc;
  logic                   do_commit;

  assign head_idx   = head[TAG_W-1:0];
  assign tail_idx   = tail[TAG_W-1:0];
  assign head_entry = entries[head_idx];

  // Same index with differing wrap bits means the tail has lapped the head.
  assign full        = (head_idx == tail_idx) && (head[TAG_W] != tail[TAG_W]);
  assign alloc_ready = ~full;
  assign alloc_tag   = tail_idx;
  assign count       = tail - head;
  assign do_alloc    = alloc_valid & ~full;
  assign do_commit   = head_entry.busy & head_entry.done;

  // NOTE: every register here is assigned with <= so all reads see pre-edge state;
  // that is what makes a head completion commit one edge later rather than immediately.
  always_ff @(posedge clk) begin
    if (!n_rst || flush) begin
      head         <= '0;
      tail         <= '0;
      commit_valid <= 1'b0;
      // NOTE: only the busy/done flags are cleared; entry payload is don't-care until
      // reallocated, so the storage array needs no reset of its data fields.
      for (int i = 0; i < DEPTH; i++) begin
        entries[i].busy <= 1'b0;
        entries[i].done <= 1'b0;
      end
      if (!n_rst) begin
        commit_write_rw     <= 1'b0;
        commit_prev_rw_addr <= '0;
        commit_write_rs     <= 1'b0;
        commit_prev_rs_addr <= '0;
      end
    end else begin
      if (cmp_a_valid && entries[cmp_a_tag].busy) entries[cmp_a_tag].done <= 1'b1;
      if (cmp_c_valid && entries[cmp_c_tag].busy) entries[cmp_c_tag].done <= 1'b1;

      if (do_alloc) begin
        entries[tail_idx] <= '{busy:         1'b1,
                               done:         1'b0,
                               write_rw:     alloc_write_rw,
                               prev_rw_addr: alloc_prev_rw_addr,
                               write_rs:     alloc_write_rs,
                               prev_rs_addr: alloc_prev_rs_addr};
        tail <= tail + PTR_W'(1);
      end

      // Retirement is last so it overrides a same-edge completion naming the head.
      if (do_commit) begin
        commit_valid           <= 1'b1;
        commit_write_rw        <= head_entry.write_rw;
        commit_prev_rw_addr    <= head_entry.prev_rw_addr;
        commit_write_rs        <= head_entry.write_rs;
        commit_prev_rs_addr    <= head_entry.prev_rs_addr;
        entries[head_idx].busy <= 1'b0;
        entries[head_idx].done <= 1'b0;
        head                   <= head + PTR_W'(1);
      end else begin
        commit_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed and queue-model checks for reorder_buffer at DEPTH=16, 32 data / 16 status regs.
module tb_reorder_buffer;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       alloc_valid = 1'b0;
  logic       alloc_ready;
  logic       alloc_write_rw = 1'b0;
  logic [4:0] alloc_prev_rw_addr = '0;
  logic       alloc_write_rs = 1'b0;
  logic [3:0] alloc_prev_rs_addr = '0;
  logic [3:0] alloc_tag;
  logic       cmp_a_valid = 1'b0;
  logic [3:0] cmp_a_tag = '0;
  logic       cmp_c_valid = 1'b0;
  logic [3:0] cmp_c_tag = '0;
  logic       flush = 1'b0;
  logic       commit_valid;
  logic       commit_write_rw;
  logic [4:0] commit_prev_rw_addr;
  logic       commit_write_rs;
  logic [3:0] commit_prev_rs_addr;
  logic [4:0] count;

  int n_vec = 0;
  int n_miscmp = 0;

  typedef struct {
    logic [3:0] tag;
    logic       wrw;
    logic [4:0] rw;
    logic       wrs;
    logic [3:0] rs;
  } exp_t;

  exp_t q[$];

  reorder_buffer dut (
    .clk                 (clk),
    .n_rst               (n_rst),
    .alloc_valid         (alloc_valid),
    .alloc_ready         (alloc_ready),
    .alloc_write_rw      (alloc_write_rw),
    .alloc_prev_rw_addr  (alloc_prev_rw_addr),
    .alloc_write_rs      (alloc_write_rs),
    .alloc_prev_rs_addr  (alloc_prev_rs_addr),
    .alloc_tag           (alloc_tag),
    .cmp_a_valid         (cmp_a_valid),
    .cmp_a_tag           (cmp_a_tag),
    .cmp_c_valid         (cmp_c_valid),
    .cmp_c_tag           (cmp_c_tag),
    .flush               (flush),
    .commit_valid        (commit_valid),
    .commit_write_rw     (commit_write_rw),
    .commit_prev_rw_addr (commit_prev_rw_addr),
    .commit_write_rs     (commit_write_rs),
    .commit_prev_rs_addr (commit_prev_rs_addr),
    .count               (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid = 1'b0;
    cmp_a_valid = 1'b0;
    cmp_c_valid = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    n_rst = 1'b0;
    step();
    step();
    n_rst = 1'b1;
  endtask

  task automatic alloc(input logic wrw, input logic [4:0] rw, input logic wrs, input logic [3:0] rs);
    alloc_valid        = 1'b1;
    alloc_write_rw     = wrw;
    alloc_prev_rw_addr = rw;
    alloc_write_rs     = wrs;
    alloc_prev_rs_addr = rs;
    step();
    alloc_valid = 1'b0;
  endtask

  task automatic complete(input logic [3:0] tag);
    cmp_a_valid = 1'b1;
    cmp_a_tag   = tag;
    step();
    cmp_a_valid = 1'b0;
  endtask

  // Consumes a commit observed after the last edge against the model queue head.
  task automatic handle_commit();
    exp_t e;
    if (commit_valid) begin
      if (q.size() == 0) begin
        check("rnd_spurious_commit", 32'(commit_valid), 0);
      end else begin
        e = q.pop_front();
        check("rnd_rw",  32'(commit_prev_rw_addr), 32'(e.rw));
        check("rnd_wrw", 32'(commit_write_rw),     32'(e.wrw));
        check("rnd_rs",  32'(commit_prev_rs_addr), 32'(e.rs));
        check("rnd_wrs", 32'(commit_write_rs),     32'(e.wrs));
      end
    end
  endtask

  initial begin
    int   mtail;
    logic acc;
    exp_t e;

    // Reset state and in-order retirement despite out-of-order completion.
    do_reset();
    check("rst_commit_valid", 32'(commit_valid), 0);
    check("rst_count",        32'(count), 0);
    check("rst_ready",        32'(alloc_ready), 1);
    check("rst_tag",          32'(alloc_tag), 0);
    check("rst_rw",           32'(commit_prev_rw_addr), 0);
    check("rst_rs",           32'(commit_prev_rs_addr), 0);
    check("rst_wrw",          32'(commit_write_rw), 0);
    for (int i = 0; i < 3; i++) begin
      check("t1_alloc_tag", 32'(alloc_tag), i);
      alloc(1'b1, 5'(5 + i), 1'b0, 4'd0);
    end
    check("t1_count3", 32'(count), 3);
    complete(4'd2);
    check("t1_no_commit_t2", 32'(commit_valid), 0);
    complete(4'd1);
    check("t1_no_commit_t1", 32'(commit_valid), 0);
    complete(4'd0);
    check("t1_no_commit_same_edge", 32'(commit_valid), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t1_commit_valid", 32'(commit_valid), 1);
      check("t1_commit_rw",    32'(commit_prev_rw_addr), 5 + i);
      check("t1_commit_wrw",   32'(commit_write_rw), 1);
    end
    check("t1_count0", 32'(count), 0);
    step();
    check("t1_idle_valid", 32'(commit_valid), 0);
    check("t1_hold_rw",    32'(commit_prev_rw_addr), 7);

    // Full buffer, refusal, wrap of the tail, full-and-commit refusal.
    do_reset();
    for (int i = 0; i < 16; i++) alloc(1'b1, 5'(i), 1'b0, 4'd0);
    check("t2_full_count", 32'(count), 16);
    check("t2_full_ready", 32'(alloc_ready), 0);
    alloc(1'b1, 5'd30, 1'b0, 4'd0);
    check("t2_refused_count", 32'(count), 16);
    complete(4'd0);
    check("t2_not_yet", 32'(commit_valid), 0);
    step();
    check("t2_commit_valid", 32'(commit_valid), 1);
    check("t2_commit_rw",    32'(commit_prev_rw_addr), 0);
    check("t2_count15",      32'(count), 15);
    check("t2_ready",        32'(alloc_ready), 1);
    check("t2_wrap_tag",     32'(alloc_tag), 0);
    alloc(1'b1, 5'd20, 1'b0, 4'd0);
    check("t2_refull", 32'(count), 16);
    complete(4'd1);
    alloc(1'b1, 5'd21, 1'b0, 4'd0);
    check("t2_fc_commit", 32'(commit_valid), 1);
    check("t2_fc_rw",     32'(commit_prev_rw_addr), 1);
    check("t2_fc_count",  32'(count), 15);

    // Dual completion of one tag, completion of an unallocated tag.
    do_reset();
    for (int i = 0; i < 4; i++) alloc(1'b1, 5'(10 + i), 1'b0, 4'd0);
    cmp_a_valid = 1'b1; cmp_a_tag = 4'd3;
    cmp_c_valid = 1'b1; cmp_c_tag = 4'd3;
    step();
    cmp_c_valid = 1'b0;
    cmp_a_tag   = 4'd9;
    step();
    cmp_a_valid = 1'b0;
    step();
    check("t3_no_commit", 32'(commit_valid), 0);
    check("t3_count4",    32'(count), 4);
    cmp_a_valid = 1'b1; cmp_a_tag = 4'd0;
    cmp_c_valid = 1'b1; cmp_c_tag = 4'd1;
    step();
    cmp_c_valid = 1'b0;
    cmp_a_tag   = 4'd2;
    step();
    cmp_a_valid = 1'b0;
    check("t3_c0", 32'(commit_prev_rw_addr), 10);
    for (int i = 1; i < 4; i++) begin
      step();
      check("t3_cv", 32'(commit_valid), 1);
      check("t3_rw", 32'(commit_prev_rw_addr), 10 + i);
    end
    step();
    check("t3_end_valid", 32'(commit_valid), 0);
    check("t3_end_count", 32'(count), 0);

    // Status-only writer.
    do_reset();
    alloc(1'b0, 5'd9, 1'b1, 4'd4);
    complete(4'd0);
    step();
    check("t4_valid", 32'(commit_valid), 1);
    check("t4_wrw",   32'(commit_write_rw), 0);
    check("t4_wrs",   32'(commit_write_rs), 1);
    check("t4_rs",    32'(commit_prev_rs_addr), 4);
    step();
    check("t4_idle",    32'(commit_valid), 0);
    check("t4_hold_rs", 32'(commit_prev_rs_addr), 4);

    // Flush beats a pending commit and a same-cycle alloc; stale completions ignored.
    do_reset();
    for (int i = 0; i < 5; i++) alloc(1'b1, 5'(i), 1'b0, 4'd0);
    complete(4'd0);
    flush       = 1'b1;
    alloc_valid = 1'b1;
    step();
    idle();
    check("t5_count",  32'(count), 0);
    check("t5_valid",  32'(commit_valid), 0);
    check("t5_tag",    32'(alloc_tag), 0);
    check("t5_ready",  32'(alloc_ready), 1);
    complete(4'd2);
    step();
    check("t5_stale_valid", 32'(commit_valid), 0);
    check("t5_stale_count", 32'(count), 0);

    // Simultaneous alloc and commit at count 8.
    do_reset();
    for (int i = 0; i < 8; i++) alloc(1'b1, 5'(i), 1'b0, 4'd0);
    complete(4'd0);
    alloc(1'b1, 5'd8, 1'b0, 4'd0);
    check("t6_commit", 32'(commit_valid), 1);
    check("t6_count8", 32'(count), 8);
    check("t6_tag",    32'(alloc_tag), 9);

    // Random alloc/complete run against a FIFO model of allocation order.
    do_reset();
    q.delete();
    mtail = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      check("rnd_ready", 32'(alloc_ready), (q.size() < 16) ? 1 : 0);
      check("rnd_tag",   32'(alloc_tag), mtail % 16);
      alloc_valid        = ($urandom_range(0, 3) != 0);
      alloc_write_rw     = 1'($urandom_range(0, 1));
      alloc_prev_rw_addr = 5'($urandom_range(0, 31));
      alloc_write_rs     = 1'($urandom_range(0, 1));
      alloc_prev_rs_addr = 4'($urandom_range(0, 15));
      acc = alloc_valid && (q.size() < 16);
      cmp_a_valid = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      if (q.size() > 0) cmp_a_tag = q[$urandom_range(0, q.size() - 1)].tag;
      cmp_c_valid = ($urandom_range(0, 2) == 0);
      cmp_c_tag   = 4'($urandom_range(0, 15));
      e = '{tag: 4'(mtail % 16), wrw: alloc_write_rw, rw: alloc_prev_rw_addr,
            wrs: alloc_write_rs, rs: alloc_prev_rs_addr};
      step();
      handle_commit();
      if (acc) begin
        q.push_back(e);
        mtail++;
      end
      check("rnd_count", 32'(count), q.size());
    end
    idle();
    for (int cyc = 0; cyc < 100 && q.size() > 0; cyc++) begin
      cmp_a_valid = 1'b1;
      cmp_a_tag   = q[0].tag;
      cmp_c_valid = 1'b1;
      cmp_c_tag   = q[q.size() - 1].tag;
      step();
      handle_commit();
    end
    idle();
    step();
    handle_commit();
    check("rnd_drained_model", q.size(), 0);
    check("rnd_drained_count", 32'(count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- In-order retirement buffer for the out-of-order core.
- Rename allocates one entry per instruction, recording which previous physical r/s mappings it overwrites.
- Execute pipes a and c mark entries complete by tag.
- Oldest complete entry retires one per cycle. The registered commit outputs drive the forwarding/free-list logic downstream, which clears calculated-list bits for released physical registers.

Parameters:
- DEPTH, 16, number of entries (power of 2, >=4)
- NUM_D_REG, 32, physical data registers
- NUM_S_REG, 16, physical status registers

Ports:
- clk  in  1  clock
- n_rst  in  1  synchronous active-low reset
- alloc_valid  in  1  rename presents an instruction
- alloc_ready  out  1  entry available
- alloc_write_rw  in  1  instruction overwrites a data mapping
- alloc_prev_rw_addr  in  $clog2(NUM_D_REG)  previous physical data reg
- alloc_write_rs  in  1  instruction overwrites a status mapping
- alloc_prev_rs_addr  in  $clog2(NUM_S_REG)  previous physical status reg
- alloc_tag  out  $clog2(DEPTH)  tag given to the allocating instruction (= tail index)
- cmp_a_valid  in  1  pipe a completes an instruction
- cmp_a_tag  in  $clog2(DEPTH)  its tag
- cmp_c_valid  in  1  pipe c completes an instruction
- cmp_c_tag  in  $clog2(DEPTH)  its tag
- flush  in  1  discard all entries
- commit_valid  out  1  one retirement this cycle
- commit_write_rw  out  1  retired entry's write_rw
- commit_prev_rw_addr  out  $clog2(NUM_D_REG)  retired entry's prev data reg
- commit_write_rs  out  1  retired entry's write_rs
- commit_prev_rs_addr  out  $clog2(NUM_S_REG)  retired entry's prev status reg
- count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Pointers: head and tail, each $clog2(DEPTH)+1 bits; MSB is the wrap bit.
  - Empty: head==tail.
  - Full: indices equal and wrap bits differ.
  - count = tail-head.
- Per-entry state: busy, done, write_rw, prev_rw_addr, write_rs, prev_rs_addr.
- alloc_ready = ~full, combinational from registered state only. It does not account for a same-cycle commit.
- Allocation (alloc_valid & alloc_ready at posedge):
  - entry[tail] is written with busy=1, done=0, payload.
  - tail increments.
  - alloc_tag = tail index, combinational.
- Completion (cmp_x_valid at posedge):
  - done of the tagged entry is set only if that entry is busy; completion to a non-busy tag is ignored.
  - a and c may name the same or different tags in one cycle; the same tag is idempotent.
- Commit:
  - At a posedge where entry[head] is busy & done, the commit_* registers load that entry's payload, commit_valid<=1, entry busy<=0, head increments.
  - Otherwise commit_valid<=0; commit payload registers hold their values.
  - At most one commit per cycle.
  - Latency: completion sampled at edge N allows commit at edge N+1, so commit_valid is high in the cycle after N+1.
- Simultaneous alloc and commit: both take effect; count is unchanged.
- Full & commit in the same cycle: alloc is still refused that cycle.
- Completion of the head entry at the same edge as a commit check: the commit happens next edge, because done is read from registered state.
- Wrap-around: index = pointer[low bits]; the wrap bit toggles on rollover.
- Flush:
  - highest priority; at that edge all busy/done <=0, head=tail=0, commit_valid<=0.
  - Same-cycle alloc, complete and commit are discarded.
- Reset (n_rst=0 at posedge):
  - same as flush, plus all commit payload registers <=0.
  - Outputs after reset: commit_*=0, count=0, alloc_ready=1, alloc_tag=0.
  - Reset mid-operation discards all in-flight entries.

Decomposition:
- rob_pkg:
  - rob_tag_t
  - rob_entry_t struct (busy, done, write_rw, prev_rw_addr, write_rs, prev_rs_addr)
  - DEPTH-derived widths
  - NUM_D_REG/NUM_S_REG from the shared nand_cpu header
- Single module; no sub-module needed. Entry storage is an array of rob_entry_t.

Test Plan:
- Reset, then alloc 3 entries (prev_rw 5,6,7, write_rw=1), complete tags 2,1,0 on successive cycles -> no commit until tag0 done. Then commit_valid high three consecutive cycles, prev_rw_addr 5,6,7 in order; count returns to 0.
- Alloc 16 with no completions -> alloc_ready=0, count=16. Complete tag0 -> commit next-next cycle; alloc_ready=1 once count=15. Alloc again gets tag 0 (wrap).
- cmp_a_tag=3 and cmp_c_tag=3 together, and cmp_a on an unallocated tag 9 -> entry 3 done once; entry 9 stays not busy; no spurious commit.
- Entry with write_rw=0, write_rs=1, prev_rs=4 -> commit_write_rw=0, commit_write_rs=1, commit_prev_rs_addr=4.
- 5 entries live, flush asserted with alloc_valid=1 -> next cycle count=0, commit_valid=0, alloc_tag=0; a later completion of old tag 2 is ignored.
- Alloc and commit in the same cycle at count=8 -> count stays 8; a 200-cycle random alloc/complete run checks the commit order against a queue model.
